// File: rtl/alarm_mode_ctrl_if.sv
// ---------------------------------------------------------------------------
// alarm_mode_ctrl_if
//   Bundles the button/switch inputs, the running time from the time counter
//   and every output of the alarm mode sequencer.
//
//   master : drives buttons, switch and running time; observes outputs
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface alarm_mode_ctrl_if;
   logic       btn_mode;
   logic       btn_sel;
   logic       btn_up;
   logic       sw_alarm_en;
   logic [5:0] seconds;
   logic [5:0] minutes;
   logic [4:0] hours;

   logic [2:0] state;
   logic [5:0] set_seconds;
   logic [5:0] set_minutes;
   logic [4:0] set_hours;
   logic [5:0] alarm_minutes;
   logic [4:0] alarm_hours;
   logic [1:0] field;
   logic       alarm_out;

   modport master (
      output btn_mode, btn_sel, btn_up, sw_alarm_en, seconds, minutes, hours,
      input  state, set_seconds, set_minutes, set_hours,
             alarm_minutes, alarm_hours, field, alarm_out
   );

   modport slave (
      input  btn_mode, btn_sel, btn_up, sw_alarm_en, seconds, minutes, hours,
      output state, set_seconds, set_minutes, set_hours,
             alarm_minutes, alarm_hours, field, alarm_out
   );
endinterface

// File: rtl/alarm_mode_ctrl.sv
// ---------------------------------------------------------------------------
// alarm_mode_ctrl
//   Mode sequencer for the alarm clock. Converts the raw buttons into single
//   pulses, walks RUN / SET_TIME / SET_ALARM / RING, holds the edit values
//   loaded by the time counter and the stored alarm time, and rings the alarm
//   when the running time reaches it.
//
//   CLK100MHZ : system clock
//   reset     : asynchronous, active-high reset
//   bus       : slave side of alarm_mode_ctrl_if
//               in  btn_mode/btn_sel/btn_up (raw levels), sw_alarm_en,
//                   seconds/minutes/hours (running time)
//               out state, set_seconds/minutes/hours, alarm_minutes/hours,
//                   field, alarm_out (all registered)
// ---------------------------------------------------------------------------
module alarm_mode_ctrl #(
   parameter int unsigned CLK_HZ         = 100000000,
   parameter int unsigned RING_SECONDS   = 60,
   parameter int unsigned ALARM_RST_HOUR = 6
) (
   input  logic              CLK100MHZ,
   input  logic              reset,
   alarm_mode_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_RUN       = 3'b000,
      ST_SET_TIME  = 3'b010,
      ST_SET_ALARM = 3'b011,
      ST_RING      = 3'b100
   } state_e;

   // 100 MHz * 60 s overflows 32 bits, so the ring length is sized in 64.
   localparam longint unsigned RING_CYCLES =
      longint'(CLK_HZ) * longint'(RING_SECONDS);
   localparam int CNT_W = (RING_CYCLES > 1) ? $clog2(RING_CYCLES) : 1;
   localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_CYCLES - 1);

   localparam logic [4:0] RST_HOUR = 5'(ALARM_RST_HOUR);

   // ------------------------------------------------------------------
   // Button conditioning: 2-flop synchronizer + rising-edge detector.
   // Bit order {mode, sel, up}.
   // ------------------------------------------------------------------
   logic [2:0] btn_raw;
   logic [2:0] sync1_q, sync2_q, prev_q;
   logic [2:0] pulse;

   assign btn_raw = {bus.btn_mode, bus.btn_sel, bus.btn_up};

   // NOTE: sequential state is always written with non-blocking assignments
   // so every flop samples the pre-edge value of its neighbours.
   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign pulse = sync2_q & ~prev_q;

   // Only the highest-priority pulse acts: mode > sel > up.
   logic mode_p, sel_p, up_p;
   assign mode_p = pulse[2];
   assign sel_p  = pulse[1] & ~pulse[2];
   assign up_p   = pulse[0] & ~pulse[2] & ~pulse[1];

   // ------------------------------------------------------------------
   // Wrap-around increments for edit fields (no carry between fields).
   // ------------------------------------------------------------------
   function automatic logic [5:0] inc_60(input logic [5:0] v);
      return (v >= 6'd59) ? 6'd0 : v + 6'd1;
   endfunction

   function automatic logic [4:0] inc_24(input logic [4:0] v);
      return (v >= 5'd23) ? 5'd0 : v + 5'd1;
   endfunction

   // ------------------------------------------------------------------
   // Sequencer state
   // ------------------------------------------------------------------
   state_e           state_q, state_d;
   logic [1:0]       field_q, field_d;
   logic [5:0]       set_s_q, set_s_d;
   logic [5:0]       set_m_q, set_m_d;
   logic [4:0]       set_h_q, set_h_d;
   logic [5:0]       alarm_m_q, alarm_m_d;
   logic [4:0]       alarm_h_q, alarm_h_d;
   logic             alarm_out_q, alarm_out_d;
   logic [CNT_W-1:0] ring_cnt_q, ring_cnt_d;
   logic             match_q, match_d;
   logic             trigger;

   // Alarm match is edge-qualified so a dismissed alarm does not re-ring
   // for the rest of the matching second.
   assign match_d = bus.sw_alarm_en &&
                    (bus.hours   == alarm_h_q) &&
                    (bus.minutes == alarm_m_q) &&
                    (bus.seconds == 6'd0);
   assign trigger = match_d && !match_q;

   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         state_q     <= ST_RUN;
         field_q     <= 2'd0;
         set_s_q     <= '0;
         set_m_q     <= '0;
         set_h_q     <= '0;
         alarm_m_q   <= '0;
         alarm_h_q   <= RST_HOUR;
         alarm_out_q <= 1'b0;
         ring_cnt_q  <= '0;
         match_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         field_q     <= field_d;
         set_s_q     <= set_s_d;
         set_m_q     <= set_m_d;
         set_h_q     <= set_h_d;
         alarm_m_q   <= alarm_m_d;
         alarm_h_q   <= alarm_h_d;
         alarm_out_q <= alarm_out_d;
         ring_cnt_q  <= ring_cnt_d;
         match_q     <= match_d;
      end
   end

   always_comb begin
      // NOTE: every next-state value defaults to "hold" before the case so
      // no path through the logic leaves a variable unassigned (no latches).
      state_d     = state_q;
      field_d     = field_q;
      set_s_d     = set_s_q;
      set_m_d     = set_m_q;
      set_h_d     = set_h_q;
      alarm_m_d   = alarm_m_q;
      alarm_h_d   = alarm_h_q;
      alarm_out_d = alarm_out_q;
      ring_cnt_d  = ring_cnt_q;

      case (state_q)
         ST_RUN: begin
            // An alarm edge outranks a coincident mode press so it is
            // never missed; sel/up are meaningless in RUN.
            if (trigger) begin
               state_d     = ST_RING;
               alarm_out_d = 1'b1;
               ring_cnt_d  = '0;
            end else if (mode_p) begin
               state_d = ST_SET_TIME;
               set_s_d = bus.seconds;
               set_m_d = bus.minutes;
               set_h_d = bus.hours;
               field_d = 2'd0;
            end
         end

         ST_SET_TIME: begin
            if (mode_p) begin
               state_d = ST_SET_ALARM;
               field_d = 2'd0;
            end else if (sel_p) begin
               field_d = (field_q >= 2'd2) ? 2'd0 : field_q + 2'd1;
            end else if (up_p) begin
               case (field_q)
                  2'd0:    set_h_d = inc_24(set_h_q);
                  2'd1:    set_m_d = inc_60(set_m_q);
                  default: set_s_d = inc_60(set_s_q);
               endcase
            end
         end

         ST_SET_ALARM: begin
            // Alarm has only hours (0) and minutes (1).
            if (mode_p) begin
               state_d = ST_RUN;
            end else if (sel_p) begin
               field_d = (field_q == 2'd0) ? 2'd1 : 2'd0;
            end else if (up_p) begin
               if (field_q == 2'd0) alarm_h_d = inc_24(alarm_h_q);
               else                 alarm_m_d = inc_60(alarm_m_q);
            end
         end

         ST_RING: begin
            if ((|pulse) || !bus.sw_alarm_en || (ring_cnt_q == RING_LAST)) begin
               state_d     = ST_RUN;
               alarm_out_d = 1'b0;
            end else begin
               ring_cnt_d = ring_cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d     = ST_RUN;
            alarm_out_d = 1'b0;
         end
      endcase
   end

   assign bus.state         = state_q;
   assign bus.field         = field_q;
   assign bus.set_seconds   = set_s_q;
   assign bus.set_minutes   = set_m_q;
   assign bus.set_hours     = set_h_q;
   assign bus.alarm_minutes = alarm_m_q;
   assign bus.alarm_hours   = alarm_h_q;
   assign bus.alarm_out     = alarm_out_q;

endmodule

// File: doc/alarm_mode_ctrl.md
Name: alarm_mode_ctrl

Overview:
- Top-level mode sequencer for the alarm clock.
- Turns the board buttons into the 3-bit `state` code and the load values (`set_seconds`/`set_minutes`/`set_hours`) consumed by the time counter.
- Holds the alarm time, compares it against the running time and drives the alarm output until it is dismissed or times out.
- Sits between the button/switch inputs and the time counter and display logic.

Parameters:
- CLK_HZ, 100000000, clock frequency; sets the ring timeout.
- RING_SECONDS, 60, maximum ring duration in seconds before auto-stop.
- ALARM_RST_HOUR, 6, alarm hour value after reset (alarm minutes reset to 0).

Ports:
- CLK100MHZ  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- btn_mode  in  1  mode button, raw level, debounced externally, asynchronous to the clock.
- btn_sel  in  1  field-select button, raw level.
- btn_up  in  1  increment button, raw level.
- sw_alarm_en  in  1  alarm enable switch, level.
- seconds  in  6  running seconds from the time counter (0-59).
- minutes  in  6  running minutes (0-59).
- hours  in  5  running hours (0-23).
- state  out  3  mode code: 3'b000 RUN, 3'b010 SET_TIME, 3'b011 SET_ALARM, 3'b100 RING.
- set_seconds  out  6  edit value; the time counter loads it while state==3'b010.
- set_minutes  out  6  edit value.
- set_hours  out  5  edit value.
- alarm_minutes  out  6  stored alarm minutes.
- alarm_hours  out  5  stored alarm hours.
- field  out  2  selected edit field: 0 hours, 1 minutes, 2 seconds (display blink).
- alarm_out  out  1  high while ringing.

Behaviour:
- Reset (async, active-high) values:
  - state=RUN, field=0, all set_* = 0, alarm_hours=ALARM_RST_HOUR, alarm_minutes=0, alarm_out=0.
  - Ring counter, synchronizers and edge registers all 0.
- Button handling:
  - Each button passes through a 2-flop synchronizer, then a rising-edge detector.
  - A press produces exactly one 1-cycle pulse, 3 clocks after the input rises.
  - A held button produces no repeat pulses.
- Priority when pulses coincide in one cycle: mode > sel > up. Only the highest-priority pulse acts; the others are discarded.
- FSM, mode pulse transitions:
  - RUN -> SET_TIME. In the same cycle, load set_* from seconds/minutes/hours and set field=0.
  - SET_TIME -> SET_ALARM. Set field=0.
  - SET_ALARM -> RUN.
  - RING -> RUN (dismiss).
- RING exits:
  - Any pulse (mode, sel or up) in RING returns to RUN and clears alarm_out.
  - Auto-stop after CLK_HZ*RING_SECONDS cycles in RING.
- sel pulse, in SET_TIME or SET_ALARM:
  - field advances 0->1->2->0 in SET_TIME.
  - field advances 0->1->0 in SET_ALARM (alarm has no seconds field).
  - Ignored in RUN.
- up pulse, in SET_TIME: increments the selected set_* field with wrap. Hours 23->0, minutes 59->0, seconds 59->0. No carry into the next field.
- up pulse, in SET_ALARM: same wrap rules applied to alarm_hours/alarm_minutes.
- up pulse in RUN: ignored.
- set_* hold their values outside SET_TIME.
- Alarm match:
  - match = sw_alarm_en && hours==alarm_hours && minutes==alarm_minutes && seconds==0, registered once (match_q).
  - Trigger = match && !match_q, evaluated only in RUN. Trigger moves state to RUN->RING and sets alarm_out=1 on the same edge.
  - Because of the edge qualification, dismissing during the matching second does not re-trigger.
  - A match that occurs while in SET_TIME or SET_ALARM is lost and is not deferred.
- Ring counter:
  - Cleared on RING entry, increments every cycle in RING.
  - At terminal count: state=RUN, alarm_out=0.
- sw_alarm_en dropping to 0 while in RING: alarm_out clears and state returns to RUN on the next cycle.
- Reset mid-operation (any state, including RING) forces all reset values immediately.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then press mode, sel, sel, up.
  - State sequence 000 -> 010; field 0 -> 1 -> 2.
  - set_seconds increments by 1 from the loaded value.
  - Each change appears exactly 3 clocks after the button rises.
- SET_TIME with field=0 and set_hours=23, press up -> set_hours=0, set_minutes unchanged. Repeat on minutes at 59 -> 0.
- Alarm set to 06:30 with sw_alarm_en=1; drive time 06:29:59 -> 06:30:00.
  - Next cycle: state=100, alarm_out=1.
  - Press up -> state=000, alarm_out=0.
  - With seconds held at 0 after dismissal, state stays 000.
- RING_SECONDS=1 with CLK_HZ scaled to 10: ring with no button press -> auto-stop exactly 10 cycles after RING entry.
- mode and up rise in the same cycle while in SET_TIME -> state=011, set_* unchanged.
- Assert reset while in RING and in SET_ALARM with field=1 -> all outputs return to reset values asynchronously, alarm_hours=6.
